multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the MIPS core. It replaces the one-shot opcode decoder with a Moore state machine that spreads each instruction over 3–5 clock cycles. This lets a single shared memory and a single ALU be reused across fetch, address calculation and execute. It sits between the instruction register's opcode field and the datapath's mux selects and write enables, and it produces the final PC enable from the ALU zero flag.

## Interface
Parameters: none.

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- opcode  input  6  IR[31:26]; sampled only in DECODE
- zero  input  1  ALU zero flag; used in BRANCH
- mem_ready  input  1  memory access complete (used only with MEM_WAIT_EN)
- PCEn  output  1  PC register load enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  output  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding (debug)
- illegal  output  1  one-cycle pulse on an unrecognised opcode

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 return to FETCH.
- Every output defaults to 0 in every state. Only the listed signals are asserted. No x values are driven.
- FETCH:
  - Asserts MemRead, IRWrite, ALUSrcB=01 and PCEn.
  - PCSource=00 and ALUOp=00.
  - Next state is DECODE.
- DECODE:
  - Asserts ALUSrcB=11, which computes the branch target into ALUOut.
  - Registers `ne_q = opcode[0]`.
  - Branches on opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 or 000101 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other opcode → FETCH, with `illegal` pulsed for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state is MEMRD for lw and MEMWR for sw, decided by a registered copy of opcode[3].
- MEMRD: MemRead=1, IorD=1. Next state is MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state is FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Next state is RTYPEWB.
- RTYPEWB: RegDst=1, RegWrite=1. Next state is FETCH.
- BRANCH:
  - ALUSrcA=1, ALUOp=01, PCSource=01.
  - PCEn = zero XOR ne_q: beq takes the branch on zero=1, bne on zero=0.
  - Next state is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state is ADDIWB.
- ADDIWB: RegWrite=1. Next state is FETCH.
- JUMP: PCSource=10, PCEn=1. Next state is FETCH.
- Instruction latency in cycles (without MEM_WAIT_EN):
  - lw: 5
  - R-type, sw, addi: 4
  - beq, bne, j: 3

## Timing
- The state register updates on the rising clk edge.
- Outputs are combinational from state only, with these exceptions:
  - PCEn also depends on zero in BRANCH.
  - PCEn and IRWrite also depend on mem_ready in FETCH when MEM_WAIT_EN is defined.
- opcode must be stable during DECODE. It is ignored in all other states.
- Reset asserted at any time:
  - State becomes FETCH immediately, without waiting for a clock edge.
  - ne_q and the lw/sw flag clear to 0.
  - `illegal` goes to 0.
  - All write enables deassert, and any in-flight instruction is abandoned.
- After reset deasserts, the first rising edge moves FETCH → DECODE. In FETCH, PCEn=1 during reset release.

## Configuration
- MULTICYCLE_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - Strobes (MemRead/MemWrite/IorD) stay asserted during the wait.
  - IRWrite and PCEn in FETCH are asserted only in the cycle with mem_ready=1.
  - The state advances only on a mem_ready=1 cycle.
  - mem_ready is ignored in every other state.
- MULTICYCLE_MEM_WAIT_EN undefined:
  - mem_ready is unused.
  - Every memory state lasts exactly one cycle, as listed in Operation.

## Test plan
- Reset mid-instruction: reset pulsed during MEMRD → state=0 immediately and all enables are 0. After release, the next edge gives state=1.
- lw: opcode=100011 → sequence 0,1,2,3,4,0. IorD=1 in state 3. MemtoReg=1 and RegWrite=1 in state 4.
- sw and R-type:
  - sw, opcode=101011 → sequence 0,1,2,5,0, with MemWrite=1 only in state 5.
  - R-type, opcode=000000 → sequence 0,1,6,7,0, with RegDst=1 and RegWrite=1 in state 7.
- Branches (each takes 3 cycles):
  - beq, zero=1 → PCEn=1 in state 8.
  - beq, zero=0 → PCEn=0.
  - bne, zero=0 → PCEn=1.
  - bne, zero=1 → PCEn=0.
- j and illegal opcode:
  - j, opcode=000010 → state 11 with PCSource=10 and PCEn=1.
  - opcode=111111 → illegal=1 for one cycle in DECODE, then FETCH, with no RegWrite or MemWrite asserted.
- With MULTICYCLE_MEM_WAIT_EN, lw with mem_ready held low 3 cycles in both FETCH and MEMRD:
  - The FSM stays in each state for 4 cycles.
  - IRWrite and PCEn pulse once.
  - Total instruction latency is 11 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer for the MIPS core: one state register, outputs decoded from state.
// Optional MULTICYCLE_MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR until mem_ready is high.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_reg;
    state_t decode_next;
    logic   ne_reg;
    logic   sw_reg;
    logic   mem_go;
    logic   opcode_legal;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go           = 1'b1;
`endif

    always_comb begin
        decode_next  = FETCH;
        opcode_legal = 1'b1;
        case (opcode)
            6'b000000:            decode_next = EXEC;
            6'b100011, 6'b101011: decode_next = MEMADR;
            6'b000100, 6'b000101: decode_next = BRANCH;
            6'b001000:            decode_next = ADDIEX;
            6'b000010:            decode_next = JUMP;
            default:              opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
            ne_reg    <= 1'b0;
            sw_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FETCH:   if (mem_go) state_reg <= DECODE;
                DECODE: begin
                    ne_reg    <= opcode[0];
                    sw_reg    <= opcode[3];
                    state_reg <= decode_next;
                end
                MEMADR:  state_reg <= sw_reg ? MEMWR : MEMRD;
                MEMRD:   if (mem_go) state_reg <= MEMWB;
                MEMWR:   if (mem_go) state_reg <= FETCH;
                EXEC:    state_reg <= RTYPEWB;
                BRANCH:  state_reg <= FETCH;
                ADDIEX:  state_reg <= ADDIWB;
                default: state_reg <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        illegal  = 1'b0;
        case (state_reg)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_go;
                PCEn    = mem_go;
                ALUSrcB = 2'b01;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                illegal = ~opcode_legal;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCEn     = zero ^ ne_reg;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
            end
            default: ;
        endcase
        // While reset is held no write enable may fire, even though state already reads FETCH.
        if (reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control against an instruction-level reference model.
// Honours MULTICYCLE_MEM_WAIT_EN when the design is built with it.
module tb_multicycle_control;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t op=%b)", tag, observed, expected, $time, opcode);
        end
    endtask

    // Output bundle order: PCEn IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal
    function automatic logic [15:0] pack_outs();
        return {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
    endfunction

    function automatic logic [15:0] mk(input bit pcen, input bit iord, input bit mrd, input bit mwr,
                                       input bit irw, input bit m2r, input bit rdst, input bit rw,
                                       input bit srca, input logic [1:0] srcb, input logic [1:0] aop,
                                       input logic [1:0] psrc, input bit ill);
        return {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
    endfunction

    // Instruction class -> list of states visited, straight from the instruction table.
    function automatic void state_list(input logic [5:0] op, output int q[$], output bit legal);
        legal = 1'b1;
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100, 6'b000101: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default: begin q = '{0, 1}; legal = 1'b0; end
        endcase
    endfunction

    function automatic logic [15:0] expected_outs(input int st, input bit z, input logic [5:0] op,
                                                  input bit mr, input bit legal);
        bit go;
        go = WAIT_EN ? mr : 1'b1;
        case (st)
            0:  return mk(go, 0, 1, 0, go, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            1:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal);
            2:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            3:  return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            4:  return mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            5:  return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            6:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
            7:  return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            8:  return mk(z ^ op[0], 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            9:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            10: return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            11: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
            default: return 16'h0;
        endcase
    endfunction

    // Entered just after a rising edge with the DUT in q[start]; returns just after the edge leaving the last state.
    task automatic run_instr(input logic [5:0] op, input bit z, input int start);
        int q[$];
        bit legal, mr, adv;
        int stall;
        state_list(op, q, legal);
        opcode = op;
        zero   = z;
        for (int i = start; i < q.size(); i++) begin
            stall = 0;
            do begin
                mr = WAIT_EN ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
                if (stall >= 8) mr = 1'b1;
                mem_ready = mr;
                @(negedge clk);
                check("state", 32'(state), 32'(q[i]));
                check("outs", 32'(pack_outs()), 32'(expected_outs(q[i], z, op, mr, legal)));
                adv = !(WAIT_EN && (q[i] == 0 || q[i] == 3 || q[i] == 5) && !mr);
                stall++;
                @(posedge clk);
                #1;
            end while (!adv);
        end
    endtask

    logic [5:0] op_table [8];

    initial begin
        op_table[0] = 6'b100011; op_table[1] = 6'b101011; op_table[2] = 6'b000000;
        op_table[3] = 6'b000100; op_table[4] = 6'b000101; op_table[5] = 6'b001000;
        op_table[6] = 6'b000010; op_table[7] = 6'b111111;

        reset = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_pcen", 32'(PCEn), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed sweep of every opcode and both zero values, then random instructions.
        for (int i = 0; i < 16; i++) run_instr(op_table[i % 8], 1'(i / 8), 0);
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_table[$urandom_range(0, 7)];
            run_instr(op, 1'($urandom_range(0, 1)), 0);
        end

        // Reset mid-instruction: abort a lw while it sits in MEMRD.
        opcode = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_memrd", 32'(state), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("rst_enables", 32'({PCEn, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk);
        #1;
        check("held_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_pcen", 32'(PCEn), 32'd1);
        check("release_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        run_instr(6'b100011, 1'b0, 1);
        run_instr(6'b000101, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
